golden_nonce_queue: RTL and testbench

Downstream stage of the miner core. It captures every new golden nonce the pipe reports into a small FIFO so that none is lost between host polls. On host request it snapshots a 16-byte result record and serialises it byte-wise to the host using the rd/wr strobe protocol of the FPGA module interface. The top level drives its 8-bit write bus from write_data, gated by select.

---
 rtl/golden_nonce_queue_if.sv | 11 +
 rtl/golden_nonce_queue.sv | 149 ++++++++++++++
 tb/tb_golden_nonce_queue.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/golden_nonce_queue_if.sv
// Host-side byte strobe bus of the golden nonce queue: request/byte strobes
// from the host and the byte currently presented back to it.
`timescale 1ns/1ps
interface golden_nonce_queue_if;
    logic       wr_start;
    logic       wr_clk;
    logic [7:0] write_data;

    modport master (output wr_start, output wr_clk, input write_data);
    modport slave  (input wr_start, input wr_clk, output write_data);
endinterface

// File: rtl/golden_nonce_queue.sv
// Buffers golden nonces from the miner core in a small FIFO and serialises a
// 16-byte snapshot (head, nonce2, hash2, status) to the host one byte per strobe edge.
`timescale 1ns/1ps
module golden_nonce_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic [31:0]            golden_nonce,
    input  logic [31:0]            nonce2,
    input  logic [31:0]            hash2,
    golden_nonce_queue_if.slave    host,
    output logic [3:0]             count,
    output logic                   overflow
);

    typedef enum logic [1:0] {IDLE, SNAP, HOLD, SHIFT} state_t;

    state_t         state_reg;
    logic [31:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [3:0]     count_reg;
    logic           overflow_reg;
    logic [31:0]    last_golden_reg;
    logic [127:0]   record_reg;
    logic [7:0]     write_data_reg;
    logic [3:0]     byte_cnt_reg;
    logic [1:0]     start_sync_reg;
    logic [3:0]     wb_reg;

    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic           new_ovf;
    logic           start_q;
    logic           byte_edge;
    logic [31:0]    head;
    logic [3:0]     count_after_pop;
    logic [7:0]     status;

    assign full            = (count_reg == 4'(DEPTH));
    assign empty           = (count_reg == 4'd0);
    assign push            = (golden_nonce != last_golden_reg);
    assign pop             = (state_reg == SNAP) && !empty;
    assign new_ovf         = push && full && !pop;
    assign start_q         = &start_sync_reg;
    // A level must be stable for three samples before a change counts as an edge.
    assign byte_edge       = (wb_reg[3] == wb_reg[2]) && (wb_reg[2] == wb_reg[1]) &&
                             (wb_reg[1] != wb_reg[0]);
    assign head            = empty ? 32'h0 : mem[rd_ptr_reg];
    assign count_after_pop = empty ? count_reg : (count_reg - 4'd1);
    assign status          = {overflow_reg, 3'b000, count_after_pop};

    assign count           = count_reg;
    assign overflow        = overflow_reg;
    assign host.write_data = write_data_reg;

    always_ff @(posedge clk) begin
        if (push && !clear)
            mem[wr_ptr_reg] <= golden_nonce;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= 4'd0;
            overflow_reg    <= 1'b0;
            last_golden_reg <= 32'h0;
        end else if (clear) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= 4'd0;
            overflow_reg    <= 1'b0;
            last_golden_reg <= 32'h0;
        end else begin
            if (push) begin
                last_golden_reg <= golden_nonce;
                wr_ptr_reg      <= wr_ptr_reg + 1'b1;
            end
            // A full push without a pop discards the oldest entry.
            if (pop || new_ovf)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop && !full)
                count_reg <= count_reg + 4'd1;
            else if (!push && pop)
                count_reg <= count_reg - 4'd1;
            if (new_ovf)
                overflow_reg <= 1'b1;
            else if (state_reg == SNAP)
                overflow_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            record_reg     <= '0;
            write_data_reg <= 8'h00;
            byte_cnt_reg   <= 4'd0;
            start_sync_reg <= 2'b00;
            wb_reg         <= 4'b0000;
        end else if (clear) begin
            state_reg      <= IDLE;
            record_reg     <= '0;
            write_data_reg <= 8'h00;
            byte_cnt_reg   <= 4'd0;
            start_sync_reg <= 2'b00;
            wb_reg         <= 4'b0000;
        end else begin
            start_sync_reg <= {start_sync_reg[0], host.wr_start};
            wb_reg         <= {wb_reg[2:0], host.wr_clk};
            write_data_reg <= record_reg[7:0];
            case (state_reg)
                IDLE: begin
                    if (start_q)
                        state_reg <= SNAP;
                end
                SNAP: begin
                    record_reg <= {24'h0, status, hash2, nonce2, head};
                    state_reg  <= HOLD;
                end
                HOLD: begin
                    if (!start_q) begin
                        byte_cnt_reg <= 4'd0;
                        state_reg    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // A fresh request mid-transfer restarts with a new snapshot.
                    if (start_q) begin
                        state_reg <= SNAP;
                    end else if (byte_edge) begin
                        record_reg   <= record_reg >> 8;
                        byte_cnt_reg <= byte_cnt_reg + 4'd1;
                        if (byte_cnt_reg == 4'd15)
                            state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_golden_nonce_queue.sv
// Directed self-checking bench for golden_nonce_queue: capture, FIFO order,
// overflow, SNAP-cycle push, abort and reset/clear behaviour.
`timescale 1ns/1ps
module tb_golden_nonce_queue;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear;
    logic [31:0] golden_nonce;
    logic [31:0] nonce2;
    logic [31:0] hash2;
    logic [3:0]  count;
    logic        overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0]   rec [16];
    logic [127:0] rec_word;

    golden_nonce_queue_if bus ();

    golden_nonce_queue #(.DEPTH(4), .AW(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .golden_nonce (golden_nonce),
        .nonce2       (nonce2),
        .hash2        (hash2),
        .host         (bus),
        .count        (count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        golden_nonce = 32'h0;
        bus.wr_start = 1'b0;
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic push(input logic [31:0] v);
        golden_nonce = v;
        tick();
    endtask

    task automatic request;
        bus.wr_start = 1'b1;
        repeat (6) tick();
        bus.wr_start = 1'b0;
        repeat (6) tick();
    endtask

    task automatic toggle;
        bus.wr_clk = ~bus.wr_clk;
        repeat (8) tick();
    endtask

    task automatic read_record;
        rec[0] = bus.write_data;
        for (int i = 1; i < 16; i++) begin
            toggle();
            rec[i] = bus.write_data;
        end
        toggle();
        for (int i = 0; i < 16; i++)
            rec_word[i*8 +: 8] = rec[i];
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) tick();
        tests_run++;
        if (bus.write_data !== 8'h00 || count !== 4'd0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hold: got wd=%h cnt=%0d ovf=%b expected 00/0/0", bus.write_data, count, overflow);
        end
        reset_n = 1'b1;
        repeat (2) tick();
        tests_run++;
        if (bus.write_data !== 8'h00 || count !== 4'd0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: got wd=%h cnt=%0d ovf=%b expected 00/0/0", bus.write_data, count, overflow);
        end
    endtask

    task automatic test_single;
        push(32'h1234ABCD);
        tick();
        tests_run++;
        if (count !== 4'd1) begin
            tests_failed++;
            $display("FAIL single_count: got %0d expected 1", count);
        end
        request();
        read_record();
        tests_run++;
        if (rec_word !== {32'h0, 32'h55667788, 32'h11223344, 32'h1234ABCD}) begin
            tests_failed++;
            $display("FAIL single_record: got %h expected %h", rec_word,
                     {32'h0, 32'h55667788, 32'h11223344, 32'h1234ABCD});
        end
        tests_run++;
        if (count !== 4'd0 || bus.write_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL single_after: got cnt=%0d wd=%h expected 0/00", count, bus.write_data);
        end
    endtask

    task automatic test_fifo_order;
        logic [31:0] vals [3];
        logic [127:0] exp_rec;
        vals[0] = 32'hAAAA0001;
        vals[1] = 32'hBBBB0002;
        vals[2] = 32'hCCCC0003;
        do_reset();
        for (int k = 0; k < 3; k++)
            push(vals[k]);
        tick();
        tests_run++;
        if (count !== 4'd3) begin
            tests_failed++;
            $display("FAIL order_count: got %0d expected 3", count);
        end
        for (int k = 0; k < 3; k++) begin
            request();
            read_record();
            exp_rec = {24'h0, 8'(2 - k), hash2, nonce2, vals[k]};
            tests_run++;
            if (rec_word !== exp_rec) begin
                tests_failed++;
                $display("FAIL order_record%0d: got %h expected %h", k, rec_word, exp_rec);
            end
        end
    endtask

    task automatic test_overflow;
        logic [127:0] exp_rec;
        do_reset();
        for (int k = 1; k <= 6; k++)
            push(32'h10000000 + 32'(k));
        tick();
        tests_run++;
        if (count !== 4'd4 || overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_state: got cnt=%0d ovf=%b expected 4/1", count, overflow);
        end
        request();
        read_record();
        exp_rec = {24'h0, 8'h83, hash2, nonce2, 32'h10000003};
        tests_run++;
        if (rec_word !== exp_rec) begin
            tests_failed++;
            $display("FAIL ovf_record1: got %h expected %h", rec_word, exp_rec);
        end
        tests_run++;
        if (count !== 4'd3 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_cleared: got cnt=%0d ovf=%b expected 3/0", count, overflow);
        end
        request();
        read_record();
        exp_rec = {24'h0, 8'h02, hash2, nonce2, 32'h10000004};
        tests_run++;
        if (rec_word !== exp_rec) begin
            tests_failed++;
            $display("FAIL ovf_record2: got %h expected %h", rec_word, exp_rec);
        end
    endtask

    task automatic test_snap_push;
        logic [127:0] exp_rec;
        do_reset();
        push(32'h20000001);
        push(32'h20000002);
        push(32'h20000003);
        push(32'h20000004);
        tick();
        tests_run++;
        if (count !== 4'd4 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL snap_full: got cnt=%0d ovf=%b expected 4/0", count, overflow);
        end
        // Start sync takes two edges, IDLE->SNAP a third; the push lands on the fourth.
        bus.wr_start = 1'b1;
        repeat (3) tick();
        golden_nonce = 32'h20000005;
        repeat (3) tick();
        bus.wr_start = 1'b0;
        repeat (6) tick();
        tests_run++;
        if (count !== 4'd4 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL snap_push_state: got cnt=%0d ovf=%b expected 4/0", count, overflow);
        end
        read_record();
        exp_rec = {24'h0, 8'h03, hash2, nonce2, 32'h20000001};
        tests_run++;
        if (rec_word !== exp_rec) begin
            tests_failed++;
            $display("FAIL snap_push_record: got %h expected %h", rec_word, exp_rec);
        end
        request();
        read_record();
        exp_rec = {24'h0, 8'h03, hash2, nonce2, 32'h20000002};
        tests_run++;
        if (rec_word !== exp_rec) begin
            tests_failed++;
            $display("FAIL snap_push_next: got %h expected %h", rec_word, exp_rec);
        end
    endtask

    task automatic test_abort;
        logic [127:0] exp_rec;
        do_reset();
        push(32'h30000001);
        push(32'h30000002);
        tick();
        request();
        repeat (5) toggle();
        tests_run++;
        if (bus.write_data !== 8'h33) begin
            tests_failed++;
            $display("FAIL abort_byte5: got %h expected 33", bus.write_data);
        end
        request();
        read_record();
        exp_rec = {24'h0, 8'h00, hash2, nonce2, 32'h30000002};
        tests_run++;
        if (rec_word !== exp_rec) begin
            tests_failed++;
            $display("FAIL abort_record: got %h expected %h", rec_word, exp_rec);
        end
        tests_run++;
        if (count !== 4'd0) begin
            tests_failed++;
            $display("FAIL abort_count: got %0d expected 0", count);
        end
    endtask

    task automatic test_reset_clear;
        do_reset();
        push(32'h40302010);
        tick();
        request();
        repeat (3) toggle();
        tests_run++;
        if (bus.write_data !== 8'h40) begin
            tests_failed++;
            $display("FAIL midshift_byte3: got %h expected 40", bus.write_data);
        end
        golden_nonce = 32'h0;
        reset_n = 1'b0;
        #2;
        tests_run++;
        if (bus.write_data !== 8'h00 || count !== 4'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got wd=%h cnt=%0d expected 00/0", bus.write_data, count);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        push(32'hA1B2C3D4);
        push(32'h55AA55AA);
        bus.wr_start = 1'b1;
        repeat (8) tick();
        tests_run++;
        if (bus.write_data !== 8'hD4 || count !== 4'd1) begin
            tests_failed++;
            $display("FAIL hold_state: got wd=%h cnt=%0d expected D4/1", bus.write_data, count);
        end
        golden_nonce = 32'h0;
        bus.wr_start = 1'b0;
        clear = 1'b1;
        #2;
        tests_run++;
        if (bus.write_data !== 8'hD4) begin
            tests_failed++;
            $display("FAIL clear_sync: got %h expected D4 before edge", bus.write_data);
        end
        tick();
        tests_run++;
        if (bus.write_data !== 8'h00 || count !== 4'd0) begin
            tests_failed++;
            $display("FAIL clear_edge: got wd=%h cnt=%0d expected 00/0", bus.write_data, count);
        end
        clear = 1'b0;
        repeat (6) tick();
        toggle();
        tests_run++;
        if (bus.write_data !== 8'h00 || count !== 4'd0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_idle: got wd=%h cnt=%0d ovf=%b expected 00/0/0", bus.write_data, count, overflow);
        end
    endtask

    initial begin
        reset_n      = 1'b1;
        clear        = 1'b0;
        golden_nonce = 32'h0;
        nonce2       = 32'h11223344;
        hash2        = 32'h55667788;
        bus.wr_start = 1'b0;
        bus.wr_clk   = 1'b0;
        tick();
        test_reset();
        test_single();
        test_fifo_order();
        test_overflow();
        test_snap_push();
        test_abort();
        test_reset_clear();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
